// File: rtl/denise_regbus_injector.sv
`default_nettype none
// ============================================================================
// Module  : denise_regbus_injector
// Brief   : Inserts queued host register writes into idle Agnus->Denise bus
//           slots; sync-flagged writes are held for a vertical-blank burst.
// Rev     : 1.0  initial release
// ============================================================================
module denise_regbus_injector #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk7_en,
    input  logic [8:1]              ags_address_in,
    input  logic [15:0]             ags_data_in,
    input  logic                    vblank,
    input  logic                    host_valid,
    output logic                    host_ready,
    input  logic [8:1]              host_address,
    input  logic [15:0]             host_data,
    input  logic                    host_sync,
    output logic [8:1]              reg_address_out,
    output logic [15:0]             data_out,
    output logic                    inject,
    output logic [$clog2(DEPTH):0]  pending
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WAIT_VB = 2'd1;
    localparam logic [1:0] c_ST_DRAIN   = 2'd2;

    logic               r_mem_sync [DEPTH];
    logic [7:0]         r_mem_addr [DEPTH];
    logic [15:0]        r_mem_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_vb_d;
    logic [1:0]         r_state;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_head_sync;
    logic               w_head_ok;
    logic               w_eligible;
    logic               w_vb_rise;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [1:0]         w_state_next;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_FULL);
    assign host_ready  = !w_full && reset_n;
    assign w_push      = host_valid && host_ready;
    assign w_head_sync = r_mem_sync[r_rd_ptr];
    assign w_vb_rise   = vblank && !r_vb_d;
    assign pending     = r_count;

    // Agnus owns every non-idle slot; the host only fills slots it left empty.
    assign w_eligible  = clk7_en && (ags_address_in == IDLE_ADDR) && !w_empty;
    assign inject      = w_eligible && w_head_ok;
    assign w_pop       = inject;

    assign reg_address_out = inject ? r_mem_addr[r_rd_ptr] : ags_address_in;
    assign data_out        = inject ? r_mem_data[r_rd_ptr] : ags_data_in;

    always_comb begin
        w_cnt_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_count + c_CNT_W'(1);
            2'b01:   w_cnt_next = r_count - c_CNT_W'(1);
            default: w_cnt_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_sync[i] <= 1'b0;
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vb_d   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_sync[r_wr_ptr] <= host_sync;
                r_mem_addr[r_wr_ptr] <= host_address;
                r_mem_data[r_wr_ptr] <= host_data;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= w_cnt_next;
            r_vb_d  <= vblank;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A burst ends when the queue empties or blanking ends, whichever is first.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_empty && w_head_sync) begin
                    w_state_next = c_ST_WAIT_VB;
                end
            end
            c_ST_WAIT_VB: begin
                if (w_vb_rise) begin
                    w_state_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_cnt_next == '0) begin
                    w_state_next = c_ST_IDLE;
                end else if (!vblank) begin
                    w_state_next = w_head_sync ? c_ST_WAIT_VB : c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_head_ok = 1'b0;
        case (r_state)
            c_ST_IDLE:    w_head_ok = !w_head_sync;
            c_ST_WAIT_VB: w_head_ok = 1'b0;
            c_ST_DRAIN:   w_head_ok = vblank;
            default:      w_head_ok = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_denise_regbus_injector.sv
`default_nettype none
// ============================================================================
// Module  : tb_denise_regbus_injector
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_denise_regbus_injector;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        clk7_en;
    logic [7:0]  ags_address_in;
    logic [15:0] ags_data_in;
    logic        vblank;
    logic        host_valid;
    logic        host_ready;
    logic [7:0]  host_address;
    logic [15:0] host_data;
    logic        host_sync;
    logic [7:0]  reg_address_out;
    logic [15:0] data_out;
    logic        inject;
    logic [2:0]  pending;

    denise_regbus_injector #(.DEPTH(DEPTH), .IDLE_ADDR(8'hFF)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk7_en         (clk7_en),
        .ags_address_in  (ags_address_in),
        .ags_data_in     (ags_data_in),
        .vblank          (vblank),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_address    (host_address),
        .host_data       (host_data),
        .host_sync       (host_sync),
        .reg_address_out (reg_address_out),
        .data_out        (data_out),
        .inject          (inject),
        .pending         (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending writes as a plain queue plus burst bookkeeping.
    typedef struct packed {
        logic        sync;
        logic [7:0]  a;
        logic [15:0] d;
    } ent_t;
    ent_t mq[$];
    bit   m_armed;   // a sync write reached the head and awaits a blanking start
    bit   m_burst;   // inside a blanking burst
    bit   m_vbprev;

    logic        o_inj, o_ready;
    logic [7:0]  o_addr;
    logic [15:0] o_data;
    logic [2:0]  o_pend;

    typedef struct {
        logic        en;
        logic [7:0]  a;
        logic [15:0] d;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        ei;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_armed  = 1'b0;
        m_burst  = 1'b0;
        m_vbprev = 1'b0;
    endtask

    // Called at posedge+1: apply inputs, check against model, advance one clock.
    task automatic cycle();
        logic        e_inj, e_ready, ok, push, rise;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        int          nsz;
        #2;
        if (mq.size() == 0)      ok = 1'b0;
        else if (m_burst)        ok = vblank;
        else if (m_armed)        ok = 1'b0;
        else                     ok = !mq[0].sync;
        e_inj   = clk7_en && (ags_address_in == 8'hFF) && (mq.size() > 0) && ok;
        e_addr  = e_inj ? mq[0].a : ags_address_in;
        e_data  = e_inj ? mq[0].d : ags_data_in;
        e_ready = (mq.size() < DEPTH);
        o_inj = inject; o_ready = host_ready; o_addr = reg_address_out;
        o_data = data_out; o_pend = pending;
        chk("m_inject",  32'(inject),          32'(e_inj));
        chk("m_addr",    32'(reg_address_out), 32'(e_addr));
        chk("m_data",    32'(data_out),        32'(e_data));
        chk("m_ready",   32'(host_ready),      32'(e_ready));
        chk("m_pending", 32'(pending),         32'(mq.size()));
        push = host_valid && e_ready;
        rise = vblank && !m_vbprev;
        nsz  = mq.size() + int'(push) - int'(e_inj);
        if (m_burst) begin
            if (nsz == 0) begin
                m_burst = 1'b0; m_armed = 1'b0;
            end else if (!vblank) begin
                m_burst = 1'b0; m_armed = mq[0].sync;
            end
        end else if (m_armed) begin
            if (rise) begin m_burst = 1'b1; m_armed = 1'b0; end
        end else if (mq.size() > 0 && mq[0].sync) begin
            m_armed = 1'b1;
        end
        if (e_inj) void'(mq.pop_front());
        if (push) mq.push_back('{host_sync, host_address, host_data});
        m_vbprev = vblank;
        @(posedge clk);
        #1;
    endtask

    // One clk7_en slot followed by three dead cycles; slot observations kept.
    logic        s_inj;
    logic [7:0]  s_addr;
    logic [15:0] s_data;
    task automatic slot_period();
        clk7_en = 1'b1;
        cycle();
        s_inj = o_inj; s_addr = o_addr; s_data = o_data;
        clk7_en = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic push_one(input logic s, input logic [7:0] a, input logic [15:0] d);
        host_valid = 1'b1; host_sync = s; host_address = a; host_data = d;
        cycle();
        host_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h80, 16'hBEEF, 8'h80, 16'hBEEF, 1'b0};
        tbl[1] = '{1'b0, 8'h80, 16'hBEEF, 8'h80, 16'hBEEF, 1'b0};
        tbl[2] = '{1'b1, 8'hFF, 16'h0000, 8'hFF, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 8'hFF, 16'h1234, 8'hFF, 16'h1234, 1'b0};
        tbl[4] = '{1'b1, 8'hC0, 16'h0F00, 8'hC0, 16'h0F00, 1'b0};
        tbl[5] = '{1'b1, 8'h01, 16'hFFFF, 8'h01, 16'hFFFF, 1'b0};

        reset_n = 1'b0; clk7_en = 1'b0; ags_address_in = 8'hFF; ags_data_in = '0;
        vblank = 1'b0; host_valid = 1'b0; host_address = '0; host_data = '0; host_sync = 1'b0;
        model_reset();
        #1;
        chk("rst_ready",   32'(host_ready), 32'd0);
        chk("rst_inject",  32'(inject),     32'd0);
        chk("rst_pending", 32'(pending),    32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Pass-through vectors with an empty queue
        for (int i = 0; i < 6; i++) begin
            clk7_en = tbl[i].en; ags_address_in = tbl[i].a; ags_data_in = tbl[i].d;
            cycle();
            chk("vec_addr",   32'(o_addr), 32'(tbl[i].ea));
            chk("vec_data",   32'(o_data), 32'(tbl[i].ed));
            chk("vec_inject", 32'(o_inj),  32'(tbl[i].ei));
        end

        // Idle-slot insert: three busy slots, then the idle one
        clk7_en = 1'b0; ags_address_in = 8'h10; ags_data_in = 16'h5555;
        push_one(1'b0, 8'hC0, 16'h0F00);
        for (int i = 0; i < 3; i++) begin
            clk7_en = 1'b1; ags_address_in = 8'h90 + 8'(i);
            cycle();
            chk("ins_busy_inject", 32'(o_inj),  32'd0);
            chk("ins_busy_pend",   32'(o_pend), 32'd1);
            clk7_en = 1'b0;
            cycle();
        end
        clk7_en = 1'b1; ags_address_in = 8'hFF;
        cycle();
        chk("ins_inject", 32'(o_inj),  32'd1);
        chk("ins_addr",   32'(o_addr), 32'h0C0);
        chk("ins_data",   32'(o_data), 32'h0F00);
        clk7_en = 1'b0;
        cycle();
        chk("ins_pend0",  32'(o_pend), 32'd0);

        // Full / backpressure
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1; host_sync = 1'b0;
            host_address = 8'hA0 + 8'(i); host_data = 16'h1000 + 16'(i);
            cycle();
            chk("full_ready_pre", 32'(o_ready), 32'd1);
        end
        host_address = 8'hA4; host_data = 16'h1004;
        cycle();
        chk("full_ready", 32'(o_ready), 32'd0);
        chk("full_pend",  32'(o_pend),  32'd4);
        clk7_en = 1'b1;
        cycle();
        chk("full_pop_inject", 32'(o_inj),   32'd1);
        chk("full_pop_addr",   32'(o_addr),  32'h0A0);
        chk("full_pop_ready",  32'(o_ready), 32'd0);
        clk7_en = 1'b0;
        cycle();
        chk("full_after_ready", 32'(o_ready), 32'd1);
        host_valid = 1'b0;
        cycle();
        chk("full_refill_pend", 32'(o_pend), 32'd4);
        for (int i = 1; i < 5; i++) begin
            clk7_en = 1'b1;
            cycle();
            chk("full_drain_addr", 32'(o_addr), 32'(8'hA0 + 8'(i)));
            chk("full_drain_data", 32'(o_data), 32'(16'h1000 + 16'(i)));
            clk7_en = 1'b0;
            cycle();
        end

        // Sync burst: held until blanking starts, then one per slot
        for (int i = 0; i < 3; i++) push_one(1'b1, 8'hB0 + 8'(i), 16'h2000 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            slot_period();
            chk("sync_hold_inject", 32'(s_inj), 32'd0);
        end
        chk("sync_hold_pend", 32'(o_pend), 32'd3);
        vblank = 1'b1;
        slot_period();
        chk("sync_edge_inject", 32'(s_inj), 32'd0);
        for (int i = 0; i < 3; i++) begin
            slot_period();
            chk("sync_burst_inject", 32'(s_inj),  32'd1);
            chk("sync_burst_addr",   32'(s_addr), 32'(8'hB0 + 8'(i)));
            chk("sync_burst_data",   32'(s_data), 32'(16'h2000 + 16'(i)));
        end
        vblank = 1'b0;
        push_one(1'b0, 8'hE0, 16'h00E0);
        slot_period();
        chk("sync_idle_inject", 32'(s_inj),  32'd1);
        chk("sync_idle_addr",   32'(s_addr), 32'h0E0);

        // Vblank cut-off after two slots
        for (int i = 0; i < 4; i++) push_one(1'b1, 8'h40 + 8'(i), 16'h3000 + 16'(i));
        slot_period();
        vblank = 1'b1;
        slot_period();
        chk("cut_edge_inject", 32'(s_inj), 32'd0);
        for (int i = 0; i < 2; i++) begin
            slot_period();
            chk("cut_a_inject", 32'(s_inj),  32'd1);
            chk("cut_a_addr",   32'(s_addr), 32'(8'h40 + 8'(i)));
        end
        vblank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            slot_period();
            chk("cut_wait_inject", 32'(s_inj), 32'd0);
        end
        chk("cut_wait_pend", 32'(o_pend), 32'd2);
        vblank = 1'b1;
        slot_period();
        chk("cut_edge2_inject", 32'(s_inj), 32'd0);
        for (int i = 2; i < 4; i++) begin
            slot_period();
            chk("cut_b_inject", 32'(s_inj),  32'd1);
            chk("cut_b_addr",   32'(s_addr), 32'(8'h40 + 8'(i)));
        end
        vblank = 1'b0;
        cycle();
        chk("cut_pend0", 32'(o_pend), 32'd0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++) push_one(1'b1, 8'h50 + 8'(i), 16'h4000 + 16'(i));
        slot_period();
        vblank = 1'b1;
        slot_period();
        slot_period();
        chk("rstm_first_inject", 32'(s_inj), 32'd1);
        clk7_en = 1'b1; ags_address_in = 8'hFF; ags_data_in = 16'h1234;
        #1;
        chk("rstm_pre_inject",  32'(inject),  32'd1);
        chk("rstm_pre_pend",    32'(pending), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("rstm_inject", 32'(inject),          32'd0);
        chk("rstm_pend",   32'(pending),         32'd0);
        chk("rstm_ready",  32'(host_ready),      32'd0);
        chk("rstm_addr",   32'(reg_address_out), 32'h0FF);
        chk("rstm_data",   32'(data_out),        32'h1234);
        vblank = 1'b0; clk7_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        clk7_en = 1'b1; ags_address_in = 8'h80; ags_data_in = 16'hBEEF;
        cycle();
        chk("rstm_post_ready", 32'(o_ready), 32'd1);
        chk("rstm_post_addr",  32'(o_addr),  32'h080);
        chk("rstm_post_data",  32'(o_data),  32'hBEEF);
        chk("rstm_post_inj",   32'(o_inj),   32'd0);

        // Randomized traffic against the model
        begin
            int vb_left;
            vb_left = $urandom_range(30, 90);
            for (int c = 0; c < 3000; c++) begin
                if (vb_left == 0) begin
                    vblank  = !vblank;
                    vb_left = $urandom_range(20, 90);
                end
                vb_left--;
                clk7_en        = ($urandom_range(0, 2) == 0);
                ags_address_in = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                ags_data_in    = 16'($urandom);
                host_valid     = ($urandom_range(0, 1) == 0);
                host_sync      = ($urandom_range(0, 9) < 3);
                host_address   = 8'($urandom);
                host_data      = 16'($urandom);
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
